dds_rom_reader: RTL and testbench
=================================

# dds_rom_reader

Read-side controller for the signed sin/cos lookup ROM. It holds a phase accumulator and turns its top bits into ROM addresses: the address MSB selects the negated half-period, and the lower bits index the stored half-wave. It drives the ROM read enable around the ROM's one-cycle registered latency and delivers samples on a valid/ready stream. It sits between the DDS configuration registers and downstream DSP (mixer, DAC formatter).

## Interface
- P_WIDTH, 32, phase accumulator width; must be > A_WIDTH+1.
- A_WIDTH, 16, ROM index width; the ROM address is A_WIDTH+1 bits including the half-period select MSB.
- D_WIDTH, 16, ROM data width; sign-magnitude, MSB is the sign.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins generation from phase 0.
- stop  in  1  pulse; ends generation after draining.
- freq_word  in  P_WIDTH  phase increment per sample; latched on start.
- phase_offset  in  P_WIDTH  added to the phase when forming the address; live.
- rom_adress  out  A_WIDTH+1  ROM address; top A_WIDTH+1 bits of (phase+phase_offset).
- rom_re  out  1  ROM read enable.
- rom_data  in  D_WIDTH  ROM output; valid the cycle after rom_re.
- sample_out  out  D_WIDTH  output sample.
- sample_valid  out  1  sample_out is valid.
- sample_ready  in  1  downstream accepts; transfer when valid&&ready.
- busy  out  1  high in RUN or DRAIN.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start → RUN; phase←0; freq_word latched.
  - stop has priority over a simultaneous start: the block stays in IDLE.
- RUN:
  - Issue a read (rom_re=1) when the pipeline slot is free: !p1_valid || output can load, where output can load = !sample_valid || sample_ready.
  - On each issue, phase←phase+freq_word, modulo 2^P_WIDTH (wrap-around is silent).
  - stop → DRAIN; no read is issued in the cycle stop is seen.
  - start is ignored.
- DRAIN:
  - No new reads.
  - → IDLE once p1_valid=0 and sample_valid=0, or when the last sample transfers.
- Pipeline:
  - p1_valid is set the cycle after an issue.
  - rom_data loads into the output register when p1_valid && output can load.
- Address hold rule: when rom_re=0, rom_adress stays constant. The ROM registers the address sign bit every cycle regardless of enable, so a moving address during a stall corrupts the held sample.
- Backpressure: sample_valid && !sample_ready holds sample_out. A pending ROM word stays in the ROM's own register, with rom_re=0 and the address held. No samples are dropped or duplicated.
- Reset (any state, including mid-stream):
  - Next cycle the block is in IDLE with p1_valid=0 and phase=0.
  - Outputs: rom_adress=0, rom_re=0, sample_out=0, sample_valid=0, busy=0.
  - In-flight data is discarded.

## Timing
- start at cycle N → RUN at N+1 with rom_re=1 → rom_data valid at N+2 → sample_valid at N+3.
- Sustained throughput is 1 sample/clk while sample_ready=1.
- sample_ready low at cycle M → rom_re=0 from M (combinational from ready), and the output is held from M+1.
- Deasserting ready for one cycle loses exactly one cycle of throughput.
- busy is registered and follows the state.

## Configuration
- DDS_TWOS_COMP_EN defined:
  - sample_out is two's complement: magnitude = rom_data[D_WIDTH-2:0]; the sample is negated when rom_data[D_WIDTH-1]=1.
  - Negative zero (sign=1, magnitude=0) outputs 0.
  - The conversion is combinational on the load path and adds no latency.
- DDS_TWOS_COMP_EN undefined: sample_out is the raw sign-magnitude rom_data.

## Test plan
- Reset, then idle: all outputs 0, busy=0, and rom_re never asserts without start.
- freq_word=2^(P_WIDTH-A_WIDTH-1), ready=1, behavioural ROM model (1-cycle latency, sign bit registered every cycle): addresses 0,1,2,…,2^(A_WIDTH+1)-1,0 in consecutive cycles; first sample_valid 3 cycles after start; each sample equals the model value.
- Random sample_ready at 30% duty over 1000 samples: output sequence identical to the ready=1 run; rom_adress stable whenever rom_re=0.
- stop with 1 read in flight and an output held by ready=0: exactly 2 more transfers, then IDLE and busy=0; start and stop in the same IDLE cycle leaves the block in IDLE.
- With DDS_TWOS_COMP_EN, D_WIDTH=16: ROM word 16'h8005 → 16'hFFFB; 16'h8000 → 16'h0000; 16'h7FFF → 16'h7FFF. Without the macro, all three pass through unchanged.
- rst asserted mid-stream with sample_valid=1: the next cycle has all outputs 0; a fresh start restarts at address 0.

Source files
------------

// File: rtl/dds_rom_reader_if.sv
// ROM read bus and output sample stream of dds_rom_reader, bundled as one interface.
interface dds_rom_reader_if #(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
);
    logic [A_WIDTH:0]   rom_adress;
    logic               rom_re;
    logic [D_WIDTH-1:0] rom_data;
    logic [D_WIDTH-1:0] sample_out;
    logic               sample_valid;
    logic               sample_ready;

    modport master (
        output rom_adress, rom_re, sample_out, sample_valid,
        input  rom_data, sample_ready
    );

    modport slave (
        input  rom_adress, rom_re, sample_out, sample_valid,
        output rom_data, sample_ready
    );
endinterface

// File: rtl/dds_rom_reader.sv
// DDS sin/cos ROM read controller: phase accumulator, ROM read pipeline, valid/ready output.
// Optional feature macro DDS_TWOS_COMP_EN: convert sign-magnitude ROM words to two's complement.
module dds_rom_reader #(
    parameter int P_WIDTH = 32,
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [P_WIDTH-1:0] freq_word,
    input  logic [P_WIDTH-1:0] phase_offset,
    output logic               busy,
    dds_rom_reader_if.master   bus
);
    localparam int AW1   = A_WIDTH + 1;
    localparam int SHIFT = P_WIDTH - A_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [P_WIDTH-1:0]        fw_p0;
    logic [P_WIDTH-1:0]        phase_p0;
    logic [A_WIDTH:0]          addr_live_p0;
    logic [A_WIDTH:0]          addr_hold_p0;
    logic                      vld_p1;
    logic signed [D_WIDTH-1:0] sample_p2;
    logic                      vld_p2;
    logic                      can_load;
    logic                      issue;
    logic                      load;
    logic                      xfer;
    logic                      launch;

    function automatic logic signed [D_WIDTH-1:0] to_sample(input logic [D_WIDTH-1:0] word);
`ifdef DDS_TWOS_COMP_EN
        logic signed [D_WIDTH-1:0] mag;
        mag = $signed({1'b0, word[D_WIDTH-2:0]});
        // Negative zero collapses to 0 because -0 == 0.
        return word[D_WIDTH-1] ? -mag : mag;
`else
        return $signed(word);
`endif
    endfunction

    // Stage p0: phase accumulator and address formation
    assign addr_live_p0 = AW1'((phase_p0 + phase_offset) >> SHIFT);
    assign can_load     = !vld_p2 || bus.sample_ready;
    assign load         = vld_p1 && can_load;
    assign xfer         = vld_p2 && bus.sample_ready;
    assign launch       = (state == IDLE) && (state_nxt == RUN);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop)
                    state_nxt = RUN;
            end
            RUN: begin
                if (stop)
                    state_nxt = DRAIN;
                else
                    issue = !vld_p1 || can_load;
            end
            DRAIN: begin
                if (!vld_p1 && (!vld_p2 || bus.sample_ready))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst)
            issue = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (launch)
            fw_p0 <= freq_word;
    end

    // The ROM latches the sign bit every cycle, so the address must not move while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            phase_p0     <= '0;
            addr_hold_p0 <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (launch)
                phase_p0 <= '0;
            else if (issue)
                phase_p0 <= phase_p0 + fw_p0;
            if (issue)
                addr_hold_p0 <= addr_live_p0;
        end
    end

    // Stage p1: ROM word in flight inside the ROM's output register
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= issue || (vld_p1 && !can_load);
    end

    // Stage p2: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            sample_p2 <= '0;
        end else if (load) begin
            vld_p2    <= 1'b1;
            sample_p2 <= to_sample(bus.rom_data);
        end else if (xfer) begin
            vld_p2 <= 1'b0;
        end
    end

    assign bus.rom_re       = issue;
    assign bus.rom_adress   = issue ? addr_live_p0 : addr_hold_p0;
    assign bus.sample_out   = sample_p2;
    assign bus.sample_valid = vld_p2;
endmodule

// File: tb/tb_dds_rom_reader.sv
// Scoreboard bench for dds_rom_reader with a behavioural ROM and a phase/sample reference model.
module tb_dds_rom_reader;
    localparam int P_WIDTH = 12;
    localparam int A_WIDTH = 6;
    localparam int D_WIDTH = 16;
    localparam int AW1     = A_WIDTH + 1;
    localparam int SHIFT   = P_WIDTH - A_WIDTH - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               busy;
    logic [P_WIDTH-1:0] freq_word;
    logic [P_WIDTH-1:0] phase_offset;

    dds_rom_reader_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

    dds_rom_reader #(.P_WIDTH(P_WIDTH), .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .busy         (busy),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: magnitude table, 1-cycle latency on read enable, sign bit latched every cycle.
    logic [D_WIDTH-2:0] rom_tbl [2**A_WIDTH];
    logic [D_WIDTH-2:0] rom_mag_q  = '0;
    logic               rom_sign_q = 1'b0;

    always @(posedge clk) begin
        rom_sign_q <= bus.rom_adress[A_WIDTH];
        if (bus.rom_re)
            rom_mag_q <= rom_tbl[bus.rom_adress[A_WIDTH-1:0]];
    end
    assign bus.rom_data = {rom_sign_q, rom_mag_q};

    int total = 0;
    int bad   = 0;
    int rd_cnt;
    int xfer_cnt;

    logic [A_WIDTH:0]   addr_q [$];
    logic [D_WIDTH-1:0] exp_q  [$];
    logic [D_WIDTH-1:0] got_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [A_WIDTH:0] model_addr(input int k, input logic [P_WIDTH-1:0] fw,
                                                   input logic [P_WIDTH-1:0] off);
        longint unsigned ph;
        ph = (longint'(k) * fw + off) % (64'd1 << P_WIDTH);
        return AW1'(ph >> SHIFT);
    endfunction

    function automatic logic [D_WIDTH-1:0] model_sample(input logic [A_WIDTH:0] a);
`ifdef DDS_TWOS_COMP_EN
        int mag;
        mag = int'(rom_tbl[a[A_WIDTH-1:0]]);
        return D_WIDTH'(a[A_WIDTH] ? -mag : mag);
`else
        return {a[A_WIDTH], rom_tbl[a[A_WIDTH-1:0]]};
`endif
    endfunction

    // Monitor: samples one time unit before each rising edge.
    logic [A_WIDTH:0]   prev_addr = '0;
    logic               prev_rst  = 1'b1;
    logic [A_WIDTH:0]   exp_a;
    logic [D_WIDTH-1:0] exp_s;

    always @(negedge clk) begin
        #4;
        if (bus.rom_re) begin
            rd_cnt++;
            if (addr_q.size() == 0) begin
                timeout("unexpected_read");
            end else begin
                exp_a = addr_q.pop_front();
                check("rom_adress", 32'(bus.rom_adress), 32'(exp_a));
            end
        end else if (!prev_rst) begin
            check("addr_hold", 32'(bus.rom_adress), 32'(prev_addr));
        end
        if (bus.sample_valid && bus.sample_ready) begin
            xfer_cnt++;
            got_log.push_back(bus.sample_out);
            if (exp_q.size() == 0) begin
                timeout("unexpected_sample");
            end else begin
                exp_s = exp_q.pop_front();
                check("sample_out", 32'(bus.sample_out), 32'(exp_s));
            end
        end
        prev_addr = bus.rom_adress;
        prev_rst  = rst;
    end

    task automatic set_ready(input int pct);
        bus.sample_ready = ($urandom_range(99) < pct);
    endtask

    // One generation run of n reads; stop is raised in the cycle after the n-th read.
    task automatic run(input int n, input logic [P_WIDTH-1:0] fw, input logic [P_WIDTH-1:0] off,
                       input int pct, input bit hold_mode, input bit chk_lat);
        int budget;
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(model_addr(k, fw, off));
            exp_q.push_back(model_sample(model_addr(k, fw, off)));
        end
        rd_cnt   = 0;
        xfer_cnt = 0;
        got_log.delete();
        @(negedge clk);
        freq_word    = fw;
        phase_offset = off;
        start        = 1'b1;
        if (hold_mode) bus.sample_ready = 1'b0; else set_ready(pct);
        @(negedge clk);
        start = 1'b0;
        if (chk_lat) begin
            check("lat_busy_n1", 32'(busy), 32'd1);
            check("lat_re_n1", 32'(bus.rom_re), 32'd1);
            check("lat_valid_n1", 32'(bus.sample_valid), 32'd0);
            @(negedge clk);
            check("lat_valid_n2", 32'(bus.sample_valid), 32'd0);
            @(negedge clk);
            check("lat_valid_n3", 32'(bus.sample_valid), 32'd1);
        end
        budget = n * 20 + 100;
        while (rd_cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (rd_cnt < n) begin
                if (hold_mode) bus.sample_ready = 1'b0; else set_ready(pct);
            end
        end
        if (budget == 0) timeout("run_reads");
        stop = 1'b1;
        if (hold_mode) check("held_valid_at_stop", 32'(bus.sample_valid), 32'd1);
        @(negedge clk);
        stop = 1'b0;
        budget = 400;
        while (busy && budget > 0) begin
            if (hold_mode) bus.sample_ready = 1'b1; else set_ready(pct);
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout("drain");
        check("xfer_count", 32'(xfer_cnt), 32'(n));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rd_count", 32'(rd_cnt), 32'(n));
    endtask

    initial begin
        int budget;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        freq_word = '0; phase_offset = '0; bus.sample_ready = 1'b0;
        rd_cnt = 0; xfer_cnt = 0;
        for (int i = 0; i < 2**A_WIDTH; i++)
            rom_tbl[i] = (D_WIDTH-1)'($urandom);
        rom_tbl[1] = 15'd5;
        rom_tbl[2] = 15'd0;
        rom_tbl[3] = 15'h7FFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr", 32'(bus.rom_adress), 32'd0);
        check("rst_re", 32'(bus.rom_re), 32'd0);
        check("rst_sample", 32'(bus.sample_out), 32'd0);
        check("rst_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.sample_ready = 1'($urandom_range(1));
            freq_word = P_WIDTH'($urandom);
            @(negedge clk);
            check("idle_re", 32'(bus.rom_re), 32'd0);
        end

        // Full address sweep with ready held high.
        bus.sample_ready = 1'b1;
        run(2**AW1 + 1, P_WIDTH'(1 << SHIFT), '0, 100, 1'b0, 1'b1);
        if (got_log.size() > 66) begin
            check("conv_7fff", 32'(got_log[3]), 32'h7FFF);
`ifdef DDS_TWOS_COMP_EN
            check("conv_8005", 32'(got_log[65]), 32'hFFFB);
            check("conv_8000", 32'(got_log[66]), 32'h0000);
`else
            check("conv_8005", 32'(got_log[65]), 32'h8005);
            check("conv_8000", 32'(got_log[66]), 32'h8000);
`endif
        end else begin
            timeout("sweep_log");
        end

        run(1000, P_WIDTH'(1 << SHIFT), '0, 30, 1'b0, 1'b0);
        run(200, P_WIDTH'($urandom), P_WIDTH'($urandom), 60, 1'b0, 1'b0);
        run(2, P_WIDTH'($urandom), P_WIDTH'($urandom), 0, 1'b1, 1'b0);
        check("drain_busy", 32'(busy), 32'd0);

        // start and stop in the same idle cycle
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_re", 32'(bus.rom_re), 32'd0);
        @(negedge clk);
        check("startstop_busy2", 32'(busy), 32'd0);

        // Reset mid-stream while a sample is presented.
        for (int k = 0; k < 40; k++) begin
            addr_q.push_back(model_addr(k, 12'd77, 12'd300));
            exp_q.push_back(model_sample(model_addr(k, 12'd77, 12'd300)));
        end
        rd_cnt = 0;
        freq_word = 12'd77; phase_offset = 12'd300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 200;
        while (!(bus.sample_valid && rd_cnt >= 5) && budget > 0) begin
            set_ready(30);
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout("rst_wait_valid");
        rst = 1'b1;
        bus.sample_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_addr", 32'(bus.rom_adress), 32'd0);
        check("mid_rst_re", 32'(bus.rom_re), 32'd0);
        check("mid_rst_sample", 32'(bus.sample_out), 32'd0);
        check("mid_rst_valid", 32'(bus.sample_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        addr_q.delete();
        exp_q.delete();
        run(10, P_WIDTH'(1 << SHIFT), '0, 100, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
